// File: rtl/vga_timing_receiver.sv
// Sink-side VGA timing recovery: samples sync/blank, recovers pixel coordinates,
// measures raster geometry and tracks lock on a stable timing stream.
module vga_timing_receiver #(
    parameter int H_CNT_W     = 11,
    parameter int V_CNT_W     = 10,
    parameter int LOCK_FRAMES = 2,
    parameter int H_TIMEOUT   = 2047
) (
    input  logic               VGA_clk,
    input  logic               reset_n,
    input  logic               VGA_hSync,
    input  logic               VGA_vSync,
    input  logic               blank_n,
    output logic [9:0]         xPixel,
    output logic [9:0]         yPixel,
    output logic               pixel_valid,
    output logic               frame_start,
    output logic [H_CNT_W-1:0] line_len,
    output logic [V_CNT_W-1:0] frame_lines,
    output logic [9:0]         active_width,
    output logic [9:0]         active_lines,
    output logic               locked,
    output logic               timing_error
);

    localparam int GF_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [H_CNT_W-1:0] H_MAX = '1;
    localparam logic [V_CNT_W-1:0] V_MAX = '1;
    localparam logic [9:0]         P_MAX = '1;
    localparam logic [H_CNT_W-1:0] H_TO  = H_CNT_W'(H_TIMEOUT);
    localparam logic [GF_W-1:0]    GF_LOCK = GF_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t state, state_n;
    logic [GF_W-1:0]    good_frames, good_frames_n;
    logic [H_CNT_W-1:0] ref_len, ref_len_n;
    logic               error_n;

    logic hs_d, vs_d, bl_d, hs_p, vs_p, bl_p;
    logic hs_fall, vs_fall, bl_fall;
    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt, lines_meas;
    logic [9:0]         x_cnt, y_cnt;

    // Idle reset levels keep the edge detectors quiet on the first clock.
    always_ff @(posedge VGA_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_d <= 1'b1;
            vs_d <= 1'b1;
            bl_d <= 1'b0;
            hs_p <= 1'b1;
            vs_p <= 1'b1;
            bl_p <= 1'b0;
        end else begin
            hs_d <= VGA_hSync;
            vs_d <= VGA_vSync;
            bl_d <= blank_n;
            hs_p <= hs_d;
            vs_p <= vs_d;
            bl_p <= bl_d;
        end
    end

    assign hs_fall = hs_p & ~hs_d;
    assign vs_fall = vs_p & ~vs_d;
    assign bl_fall = bl_p & ~bl_d;

    // A line whose hSync fall coincides with the vSync fall belongs to the ending frame.
    assign lines_meas = (hs_fall && v_cnt != V_MAX) ? v_cnt + 1'b1 : v_cnt;

    always_ff @(posedge VGA_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            if (hs_fall) begin
                h_cnt    <= H_CNT_W'(1);
                line_len <= h_cnt;
            end else if (h_cnt != H_MAX) begin
                h_cnt <= h_cnt + 1'b1;
            end
            if (vs_fall) begin
                frame_lines <= lines_meas;
                v_cnt       <= '0;
            end else begin
                v_cnt <= lines_meas;
            end
        end
    end

    always_ff @(posedge VGA_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt        <= '0;
            y_cnt        <= '0;
            xPixel       <= '0;
            yPixel       <= '0;
            pixel_valid  <= 1'b0;
            frame_start  <= 1'b0;
            active_width <= '0;
            active_lines <= '0;
        end else begin
            pixel_valid <= bl_d;
            xPixel      <= x_cnt;
            yPixel      <= y_cnt;
            frame_start <= vs_fall;
            if (!bl_d) begin
                x_cnt <= '0;
            end else if (x_cnt != P_MAX) begin
                x_cnt <= x_cnt + 1'b1;
            end
            if (bl_fall) begin
                active_width <= x_cnt;
            end
            if (vs_fall) begin
                active_lines <= y_cnt;
                y_cnt        <= '0;
            end else if (bl_fall && y_cnt != P_MAX) begin
                y_cnt <= y_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge VGA_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SEARCH;
            good_frames  <= '0;
            ref_len      <= '0;
            timing_error <= 1'b0;
        end else begin
            state        <= state_n;
            good_frames  <= good_frames_n;
            ref_len      <= ref_len_n;
            timing_error <= error_n;
        end
    end

    // ref_len of zero marks "no reference line measured yet" in MEASURE.
    always_comb begin
        state_n       = state;
        good_frames_n = good_frames;
        ref_len_n     = ref_len;
        error_n       = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_n       = MEASURE;
                    good_frames_n = '0;
                    ref_len_n     = '0;
                end
            end
            MEASURE: begin
                if (h_cnt == H_TO) begin
                    state_n = SEARCH;
                end else if (hs_fall && ref_len != '0 && h_cnt != ref_len) begin
                    state_n = SEARCH;
                end else begin
                    if (hs_fall && ref_len == '0) begin
                        ref_len_n = h_cnt;
                    end
                    if (vs_fall) begin
                        if (good_frames == '0 || lines_meas == frame_lines) begin
                            good_frames_n = good_frames + 1'b1;
                        end else begin
                            good_frames_n = GF_W'(1);
                        end
                        if (good_frames_n >= GF_LOCK) begin
                            state_n = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if ((h_cnt == H_TO) || (hs_fall && h_cnt != ref_len) ||
                    (vs_fall && lines_meas != frame_lines)) begin
                    state_n = SEARCH;
                    error_n = 1'b1;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver: a raster generator drives the pins, a scoreboard
// checks the pixel stream and per-scenario tasks check lock/measurement behaviour.
module tb_vga_timing_receiver;

    localparam int H_TOTAL = 794;
    localparam int H_SYNC  = 92;
    localparam int H_ACT0  = 144;
    localparam int H_ACT   = 640;
    localparam int V_TOTAL = 7;
    localparam int V_SYNC  = 2;
    localparam int V_ACT0  = 3;
    localparam int V_ACT   = 3;

    logic        VGA_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        VGA_hSync = 1'b1;
    logic        VGA_vSync = 1'b1;
    logic        blank_n = 1'b0;
    logic [9:0]  xPixel, yPixel;
    logic        pixel_valid, frame_start, locked, timing_error;
    logic [10:0] line_len;
    logic [9:0]  frame_lines, active_width, active_lines;

    vga_timing_receiver #(
        .H_CNT_W(11), .V_CNT_W(10), .LOCK_FRAMES(2), .H_TIMEOUT(2047)
    ) dut (
        .VGA_clk(VGA_clk), .reset_n(reset_n), .VGA_hSync(VGA_hSync),
        .VGA_vSync(VGA_vSync), .blank_n(blank_n), .xPixel(xPixel), .yPixel(yPixel),
        .pixel_valid(pixel_valid), .frame_start(frame_start), .line_len(line_len),
        .frame_lines(frame_lines), .active_width(active_width),
        .active_lines(active_lines), .locked(locked), .timing_error(timing_error)
    );

    always #5 VGA_clk = ~VGA_clk;

    typedef struct packed {
        logic       v;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    bit   sb_en = 1'b0;

    int gl = V_TOTAL - 1;
    int gp = 0;
    int cur_len = H_TOTAL;
    int short_line = -1;
    int vs_pos = 300;
    int vs_falls = 0;
    bit prev_vs = 1'b1;

    // Output seen at a negedge belongs to the stimulus driven two edges earlier.
    always @(negedge VGA_clk) begin
        if (sb_en && sb_q.size() >= 3) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (pixel_valid !== mon_e.v || frame_start !== mon_e.fs ||
                (mon_e.v && (xPixel !== mon_e.x || yPixel !== mon_e.y))) begin
                failures++;
                $display("FAIL pixel_stream got v=%0b fs=%0b x=%0d y=%0d want v=%0b fs=%0b x=%0d y=%0d",
                         pixel_valid, frame_start, xPixel, yPixel,
                         mon_e.v, mon_e.fs, mon_e.x, mon_e.y);
            end
        end
    end

    task automatic drive(input logic hs, input logic vs, input logic bl,
                         input logic [9:0] x, input logic [9:0] y);
        exp_t e;
        @(posedge VGA_clk);
        #1;
        VGA_hSync = hs;
        VGA_vSync = vs;
        blank_n   = bl;
        e.v  = bl;
        e.fs = prev_vs & ~vs;
        e.x  = x;
        e.y  = y;
        if (e.fs) vs_falls++;
        if (sb_en) sb_q.push_back(e);
        prev_vs = vs;
    endtask

    task automatic gen_step();
        int t;
        logic hs, vs, bl;
        t  = gl * H_TOTAL + gp;
        hs = (gp >= H_SYNC);
        vs = !(t >= vs_pos && t < vs_pos + V_SYNC * H_TOTAL);
        bl = (gl >= V_ACT0 && gl < V_ACT0 + V_ACT && gp >= H_ACT0 && gp < H_ACT0 + H_ACT);
        drive(hs, vs, bl, 10'(gp - H_ACT0), 10'(gl - V_ACT0));
        gp++;
        if (gp == cur_len) begin
            gp = 0;
            gl = (gl == V_TOTAL - 1) ? 0 : gl + 1;
            cur_len = H_TOTAL;
            if (gl == short_line) begin
                cur_len = H_TOTAL - 1;
                short_line = -1;
            end
        end
    endtask

    task automatic run_to(input int l, input int p);
        while (!(gl == l && gp == p)) gen_step();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge VGA_clk);
        #1;
        checks++;
        if ({pixel_valid, frame_start, locked, timing_error} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000", {pixel_valid, frame_start, locked, timing_error});
        end
        checks++;
        if ({line_len, frame_lines, active_width, active_lines} !== 41'b0) begin
            failures++;
            $display("FAIL reset_measures got len=%0d lines=%0d w=%0d h=%0d want 0",
                     line_len, frame_lines, active_width, active_lines);
        end
        reset_n = 1'b1;
        sb_en = 1'b1;
        repeat (3) drive(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic test_lock();
        int f0;
        f0 = vs_falls;
        while (vs_falls < f0 + 3) gen_step();
        gen_step();
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_early got=%0b want=0", locked);
        end
        gen_step();
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_third_vsync got=%0b want=1", locked);
        end
        checks++;
        if (line_len !== 11'd794 || frame_lines !== 10'd7) begin
            failures++;
            $display("FAIL measure_hv got len=%0d lines=%0d want 794 7", line_len, frame_lines);
        end
        checks++;
        if (active_width !== 10'd640 || active_lines !== 10'd3) begin
            failures++;
            $display("FAIL measure_active got w=%0d h=%0d want 640 3", active_width, active_lines);
        end
    endtask

    task automatic test_pixels();
        run_to(V_ACT0, H_ACT0);
        repeat (3) gen_step();
        checks++;
        if (pixel_valid !== 1'b1 || xPixel !== 10'd0 || yPixel !== 10'd0) begin
            failures++;
            $display("FAIL first_pixel got v=%0b x=%0d y=%0d want 1 0 0", pixel_valid, xPixel, yPixel);
        end
        run_to(V_ACT0 + V_ACT - 1, H_ACT0 + H_ACT - 1);
        repeat (3) gen_step();
        checks++;
        if (pixel_valid !== 1'b1 || xPixel !== 10'd639 || yPixel !== 10'd2) begin
            failures++;
            $display("FAIL last_pixel got v=%0b x=%0d y=%0d want 1 639 2", pixel_valid, xPixel, yPixel);
        end
        gen_step();
        checks++;
        if (pixel_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_last_pixel got v=%0b want 0", pixel_valid);
        end
    endtask

    task automatic test_short_line();
        int f0;
        short_line = 4;
        run_to(5, 0);
        gen_step();
        gen_step();
        checks++;
        if (timing_error !== 1'b0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL short_pre got err=%0b lock=%0b want 0 1", timing_error, locked);
        end
        gen_step();
        checks++;
        if (timing_error !== 1'b1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL short_err got err=%0b lock=%0b want 1 0", timing_error, locked);
        end
        gen_step();
        checks++;
        if (timing_error !== 1'b0) begin
            failures++;
            $display("FAIL short_pulse_width got err=%0b want 0", timing_error);
        end
        f0 = vs_falls;
        while (vs_falls < f0 + 3) gen_step();
        gen_step();
        gen_step();
        checks++;
        if (locked !== 1'b1 || line_len !== 11'd794) begin
            failures++;
            $display("FAIL short_relock got lock=%0b len=%0d want 1 794", locked, line_len);
        end
    endtask

    task automatic test_vsync_coincident();
        int f0;
        int errs;
        errs = 0;
        run_to(V_TOTAL - 1, 0);
        vs_pos = 0;
        f0 = vs_falls;
        while (vs_falls < f0 + 1) begin
            gen_step();
            errs += int'(timing_error);
        end
        repeat (2) begin
            gen_step();
            errs += int'(timing_error);
        end
        checks++;
        if (frame_lines !== 10'd7 || errs !== 0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL coincident got lines=%0d errs=%0d lock=%0b want 7 0 1", frame_lines, errs, locked);
        end
        while (!(gl == V_TOTAL - 1 && gp == 0)) begin
            gen_step();
            errs += int'(timing_error);
        end
        vs_pos = 300;
        checks++;
        if (errs !== 0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL coincident_hold got errs=%0d lock=%0b want 0 1", errs, locked);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        repeat (2100) begin
            drive(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
            pulses += int'(timing_error);
        end
        checks++;
        if (pulses !== 1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL timeout got pulses=%0d lock=%0b want 1 0", pulses, locked);
        end
        repeat (3) gen_step();
        checks++;
        if (line_len !== 11'd2047) begin
            failures++;
            $display("FAIL h_saturate got len=%0d want 2047", line_len);
        end
    endtask

    task automatic test_reset_midline();
        int f0;
        int fs_seen;
        run_to(4, 400);
        repeat (3) gen_step();
        sb_en = 1'b0;
        sb_q.delete();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pixel_valid, frame_start, locked, timing_error} !== 4'b0 ||
            xPixel !== 10'd0 || yPixel !== 10'd0) begin
            failures++;
            $display("FAIL async_reset_flags got v=%0b fs=%0b lock=%0b err=%0b x=%0d y=%0d want 0",
                     pixel_valid, frame_start, locked, timing_error, xPixel, yPixel);
        end
        checks++;
        if ({line_len, frame_lines, active_width, active_lines} !== 41'b0) begin
            failures++;
            $display("FAIL async_reset_measures got len=%0d lines=%0d w=%0d h=%0d want 0",
                     line_len, frame_lines, active_width, active_lines);
        end
        run_to(V_TOTAL - 1, 100);
        reset_n = 1'b1;
        sb_en = 1'b1;
        fs_seen = 0;
        f0 = vs_falls;
        while (vs_falls < f0 + 1) begin
            gen_step();
            fs_seen += int'(frame_start);
        end
        checks++;
        if (fs_seen !== 0) begin
            failures++;
            $display("FAIL no_false_frame_start got=%0d want 0", fs_seen);
        end
        gen_step();
        gen_step();
        checks++;
        if (frame_start !== 1'b1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL frame_start_after_reset got fs=%0b lock=%0b want 1 0", frame_start, locked);
        end
        repeat (4) gen_step();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock();
        test_pixels();
        test_short_line();
        test_vsync_coincident();
        test_timeout();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
